// File: rtl/lpf_sequencer.sv
// lpf_sequencer: scans a threshold table, picks a low-pass band and drives one-hot relays break-before-make; LPF_HYST_EN adds hysteresis
module lpf_sequencer #(
   parameter int NUM_LPF      = 7,
   parameter int BREAK_CYCLES = 4096,
   parameter int HYST_HZ      = 10000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [31:0]        frequency,
   input  logic               ptt,
   input  logic               thr_we,
   input  logic [3:0]         thr_addr,
   input  logic [31:0]        thr_data,
   output logic [NUM_LPF-1:0] LPF,
   output logic [3:0]         band,
   output logic               busy
);
   localparam int BW = $clog2(BREAK_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, SCAN, DECIDE, HOLD, BREAK, MAKE} state_t;

   if (NUM_LPF < 2 || NUM_LPF > 16 || BREAK_CYCLES < 1 || HYST_HZ < 0) begin : g_param_check
      $error("lpf_sequencer: illegal parameter value");
   end

   state_t             state_q, state_d;
   logic [31:0]        freq_q, freq_d;
   logic [3:0]         idx_q, idx_d;
   logic [3:0]         tgt_q, tgt_d;
   logic [BW-1:0]      bcnt_q, bcnt_d;
   logic [NUM_LPF-1:0] lpf_q, lpf_d;
   logic [3:0]         band_q, band_d;
   logic               applied_q, applied_d;
   logic [31:0]        thr_q [16];
   logic [31:0]        thr_d [16];
   logic               wr_ok;
   logic               accept;

   assign wr_ok = thr_we && (thr_addr < 4'(NUM_LPF - 1));

`ifdef LPF_HYST_EN
   logic [32:0] up_lim, dn_lim;
   logic [31:0] up_sat, dn_sat;
   // Saturating band edges widened/narrowed by the hysteresis margin
   always_comb begin
      up_lim = {1'b0, thr_q[band_q]} + 33'(HYST_HZ);
      dn_lim = {1'b0, thr_q[band_q - 4'd1]} - 33'(HYST_HZ);
      up_sat = up_lim[32] ? '1 : up_lim[31:0];
      dn_sat = dn_lim[32] ? '0 : dn_lim[31:0];
      accept = !applied_q || (tgt_q > band_q ? freq_q > up_sat : freq_q <= dn_sat);
   end
`else
   assign accept = 1'b1;
`endif

   // Threshold table write port; entries beyond the table are never written
   always_comb begin
      thr_d = thr_q;
      if (wr_ok) thr_d[thr_addr] = thr_data;
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      freq_d    = freq_q;
      idx_d     = idx_q;
      tgt_d     = tgt_q;
      bcnt_d    = bcnt_q;
      lpf_d     = lpf_q;
      band_d    = band_q;
      applied_d = applied_q;
      case (state_q)
         IDLE: begin
            state_d = SCAN;
            freq_d  = frequency;
            idx_d   = '0;
            tgt_d   = '0;
         end
         SCAN: begin
            if (wr_ok) begin
               freq_d = frequency;
               idx_d  = '0;
               tgt_d  = '0;
            end else begin
               tgt_d = tgt_q + 4'(freq_q > thr_q[idx_q]);
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'(NUM_LPF - 2)) state_d = DECIDE;
            end
         end
         DECIDE: begin
            if (applied_q && (tgt_q == band_q || !accept)) state_d = IDLE;
            else begin
               state_d = ptt ? HOLD : BREAK;
               bcnt_d  = '0;
               lpf_d   = ptt ? lpf_q : '0;
            end
         end
         HOLD: begin
            if (!ptt) begin
               state_d = SCAN;
               freq_d  = frequency;
               idx_d   = '0;
               tgt_d   = '0;
            end
         end
         BREAK: begin
            if (bcnt_q != BW'(BREAK_CYCLES - 1)) bcnt_d = bcnt_q + 1'b1;
            else if (!ptt) begin
               state_d   = MAKE;
               lpf_d     = {{(NUM_LPF-1){1'b0}}, 1'b1} << tgt_q;
               band_d    = tgt_q;
               applied_d = 1'b1;
            end
         end
         MAKE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops the relays and restores the default table
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         freq_q    <= '0;
         idx_q     <= '0;
         tgt_q     <= '0;
         bcnt_q    <= '0;
         lpf_q     <= '0;
         band_q    <= '0;
         applied_q <= 1'b0;
         thr_q     <= '{0: 32'd2400000, 1: 32'd4500000, 2: 32'd8000000, 3: 32'd15000000,
                        4: 32'd25000000, 5: 32'd32000000, default: 32'hFFFF_FFFF};
      end else begin
         state_q   <= state_d;
         freq_q    <= freq_d;
         idx_q     <= idx_d;
         tgt_q     <= tgt_d;
         bcnt_q    <= bcnt_d;
         lpf_q     <= lpf_d;
         band_q    <= band_d;
         applied_q <= applied_d;
         thr_q     <= thr_d;
      end
   end

   assign LPF  = lpf_q;
   assign band = band_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_lpf_sequencer.sv
// tb_lpf_sequencer: randomized and directed band-selection checks against a threshold-count reference model
module tb_lpf_sequencer;
   localparam int N   = 7;
   localparam int B   = 8;
   localparam int H   = 10000;
   localparam int LAT = 2 * (N + 1) + B + 1;

   logic         clock = 0, reset = 1, ptt = 0, thr_we = 0;
   logic [31:0]  frequency = 0, thr_data = 0;
   logic [3:0]   thr_addr = 0;
   logic [N-1:0] LPF;
   logic [3:0]   band;
   logic         busy;

   int           total = 0, bad = 0;
   logic [31:0]  dflt [0:N-2] = '{32'd2400000, 32'd4500000, 32'd8000000, 32'd15000000, 32'd25000000, 32'd32000000};
   logic [31:0]  thr_m [0:N-2];
   int           cur = 0;
   bit           applied_m = 0;
   int           zrun = 0, last_run = 0;
   logic [N-1:0] prev_lpf = '0;
   logic         prev_ptt = 0, prev_rst = 1;

   lpf_sequencer #(.NUM_LPF(N), .BREAK_CYCLES(B), .HYST_HZ(H)) dut (
      .clock(clock), .reset(reset), .frequency(frequency), .ptt(ptt),
      .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
      .LPF(LPF), .band(band), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int b);
      oh = '0;
      oh[b] = 1'b1;
   endfunction

   // band the model expects after the DUT has settled on frequency f
   function automatic int want(input logic [31:0] f);
      int t = 0;
      longint lim;
      for (int k = 0; k < N - 1; k++) if (f > thr_m[k]) t++;
`ifdef LPF_HYST_EN
      if (applied_m && t > cur) begin
         lim = longint'(thr_m[cur]) + H;
         if (lim > 64'hFFFF_FFFF) lim = 64'hFFFF_FFFF;
         if (longint'(f) <= lim) t = cur;
      end else if (applied_m && t < cur) begin
         lim = longint'(thr_m[cur-1]) - H;
         if (lim < 0) lim = 0;
         if (longint'(f) > lim) t = cur;
      end
`else
      lim = 0;
`endif
      return t;
   endfunction

   // relays are one-hot or off, never move while ptt is high, and zero runs are measured
   always @(negedge clock) begin
      if (!reset) begin
         chk("onehot", 32'($countones(LPF) <= 1), 1);
         if (!prev_rst && prev_ptt) chk("ptt_frozen", LPF, prev_lpf);
         if (LPF == 0) zrun++;
         else begin
            if (zrun != 0) last_run = zrun;
            zrun = 0;
         end
      end else zrun = 0;
      prev_lpf = LPF;
      prev_ptt = ptt;
      prev_rst = reset;
   end

   task automatic settle(input string tag, input int e, input int lim);
      int n = 0;
      while (LPF !== oh(e) && n < lim) begin
         @(negedge clock);
         n++;
      end
      #1;
      chk({tag, "_lpf"}, LPF, oh(e));
      chk({tag, "_band"}, band, e);
      cur = e;
      applied_m = 1;
   endtask

   task automatic step(input string tag, input logic [31:0] f);
      int e = want(f);
      bit changed = (e != cur);
      @(posedge clock);
      #1 frequency = f;
      last_run = 0;
      settle(tag, e, LAT + 1);
      if (changed) chk({tag, "_break"}, last_run, B);
      repeat (LAT) @(negedge clock);
      chk({tag, "_stable"}, LPF, oh(e));
   endtask

   task automatic wait_off(input string tag);
      int n = 0;
      while (LPF !== '0 && n < LAT + 1) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_off"}, LPF, 0);
   endtask

   initial begin
      logic [31:0] f;
      for (int k = 0; k < N - 1; k++) thr_m[k] = dflt[k];
      frequency = 32'd7100000;
      repeat (3) @(negedge clock);
      chk("rst_lpf", LPF, 0);
      chk("rst_band", band, 0);
      chk("rst_busy", busy, 0);
      @(posedge clock);
      #1 reset = 0;
      settle("first", 2, LAT + 4);
      chk("first_break", 32'(last_run >= B), 1);

      step("b3", 32'd14200000);
      step("b4", 32'd21200000);

      step("p_lo", 32'd3600000);
      @(posedge clock);
      #1 ptt = 1;
      frequency = 32'd50000000;
      repeat (40) @(negedge clock);
      chk("ptt_hold_lpf", LPF, 7'b0000010);
      chk("ptt_hold_busy", busy, 1);
      @(posedge clock);
      #1 ptt = 0;
      last_run = 0;
      settle("ptt_rel", want(32'd50000000), LAT + 1);
      chk("ptt_rel_break", last_run, B);

      @(posedge clock);
      #1 frequency = 32'd10000000;
      wait_off("bp");
      @(posedge clock);
      #1 ptt = 1;
      repeat (20) @(negedge clock);
      chk("bp_lpf", LPF, 0);
      chk("bp_busy", busy, 1);
      @(posedge clock);
      #1 ptt = 0;
      settle("bp_rel", want(32'd10000000), LAT + 1);

`ifdef LPF_HYST_EN
      step("h_b3", 32'd14200000);
      step("h_in", 32'd15005000);
      step("h_up", 32'd15010001);
      step("h_back", 32'd14995000);
`endif

      step("lo", 32'd2000000);
      begin
         int n = 0;
         while (busy !== 1'b0 && n < LAT) begin
            @(negedge clock);
            n++;
         end
         chk("idle_seen", busy, 0);
      end
      @(posedge clock);
      #1 thr_we = 1;
      thr_addr = 4'd0;
      thr_data = 32'd1800000;
      @(posedge clock);
      #1 thr_we = 0;
      thr_m[0] = 32'd1800000;
      last_run = 0;
      settle("wr", want(32'd2000000), LAT + 1);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) f = thr_m[$urandom_range(0, N - 2)] + $urandom_range(0, 2) - 1;
         else f = $urandom_range(0, 40000000);
         step("rnd", f);
      end

      @(posedge clock);
      #1 frequency = 32'd30000000;
      wait_off("rb");
      repeat (3) @(negedge clock);
      #2 reset = 1;
      #1;
      chk("rb_lpf", LPF, 0);
      chk("rb_band", band, 0);
      chk("rb_busy", busy, 0);
      @(posedge clock);
      #1 reset = 0;
      for (int k = 0; k < N - 1; k++) thr_m[k] = dflt[k];
      cur = 0;
      applied_m = 0;
      settle("post_rst", want(32'd30000000), LAT + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lpf_sequencer.md
LPF_SEQUENCER -- requirements
Module: lpf_sequencer

Interface
REQ-001 Parameter NUM_LPF, default 7: number of low-pass filters and bands; legal range 2..16.
REQ-002 Parameter BREAK_CYCLES, default 4096: clock cycles with all filter relays off between deselecting one filter and selecting the next; minimum 1.
REQ-003 Parameter HYST_HZ, default 10000: hysteresis margin in Hz used when LPF_HYST_EN is defined.
REQ-004 clock  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frequency  input  32  current tuned frequency in Hz; may change on any cycle.
REQ-007 ptt  input  1  transmit active; filter relays never switch while high.
REQ-008 thr_we  input  1  threshold table write strobe, one cycle per write.
REQ-009 thr_addr  input  4  threshold index to write; writes with index >= NUM_LPF-1 are ignored.
REQ-010 thr_data  input  32  threshold value in Hz.
REQ-011 LPF  output  NUM_LPF  one-hot filter relay drive; bit i selects band i; all-zero means no filter.
REQ-012 band  output  4  index of the currently applied band.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The threshold table has NUM_LPF-1 unsigned 32-bit entries, thr[0..NUM_LPF-2], in ascending order; programming a non-ascending table is a software error, and band is still the count of exceeded entries.
REQ-015 Target band = number of entries k for which the latched frequency > thr[k] (strict compare); band 0 is the lowest filter.
REQ-016 FSM states: IDLE, SCAN, DECIDE, HOLD, BREAK, MAKE.
REQ-017 IDLE -> SCAN on the next cycle, unconditionally, so scanning is continuous.
REQ-018 On SCAN entry, frequency is latched; SCAN compares one entry per cycle (NUM_LPF-1 cycles), then goes to DECIDE.
REQ-019 A thr_we to a valid address during SCAN restarts SCAN with a fresh frequency latch; writes in other states take effect at the next SCAN.
REQ-020 DECIDE: if the target band equals band and a filter is applied -> IDLE; otherwise, if ptt=1 -> HOLD, else -> BREAK.
REQ-021 HOLD: LPF and band are unchanged; when ptt=0 -> SCAN (re-evaluate, do not reuse the stale target).
REQ-022 BREAK: LPF=0 for exactly BREAK_CYCLES cycles, then -> MAKE; if ptt rises during BREAK, BREAK completes and MAKE is deferred until ptt=0.
REQ-023 MAKE (one cycle): band <= target, LPF <= one-hot(target), -> IDLE.
REQ-024 Worst-case latency from a frequency change to the new LPF is 2*(NUM_LPF+1)+BREAK_CYCLES+1 cycles with ptt=0.
REQ-025 Threshold-plus-hysteresis arithmetic uses 33 bits and saturates at 0 and 2^32-1; no wrap-around.

Reset
REQ-026 While reset is high: LPF=0, band=0, busy=0, state IDLE, no filter applied; the threshold table loads defaults 2400000, 4500000, 8000000, 15000000, 25000000, 32000000 into entries 0..5 and 32'hFFFFFFFF into any higher entry.
REQ-027 After reset deassertion, the first DECIDE always goes through BREAK/MAKE (or HOLD if ptt=1), because no filter is applied yet.
REQ-028 Reset asserted mid-BREAK or mid-HOLD aborts immediately to the reset values; no partial one-hot is ever driven.
REQ-029 LPF is at all times either all-zero or exactly one-hot.

Configuration
REQ-030 Macro LPF_HYST_EN defined: in DECIDE, a change to a higher band is accepted only if frequency > thr[band]+HYST_HZ, and a change to a lower band only if frequency <= thr[band-1]-HYST_HZ; otherwise the FSM goes to IDLE without change; the hysteresis does not apply to the first selection after reset.
REQ-031 Macro LPF_HYST_EN undefined: DECIDE uses the raw target band only, and the HYST_HZ parameter is unused.

Verification
REQ-032 Reset with NUM_LPF=7, BREAK_CYCLES=8, frequency=7100000, ptt=0 -> after reset release, LPF=0 for 8 cycles, then LPF=7'b0000100 and band=2.
REQ-033 frequency 14200000 -> 21200000 -> exactly 8 consecutive cycles of LPF=0, then LPF=7'b0010000, band=4; LPF is never multi-hot.
REQ-034 ptt=1, frequency changed 3600000 -> 50000000 -> LPF is held at 7'b0000010 while ptt=1; after ptt=0, LPF=7'b1000000 within 2*8+8+1 cycles.
REQ-035 LPF_HYST_EN defined, HYST_HZ=10000, band=3 (thr[3]=15000000): frequency 15005000 -> no change; frequency 15010001 -> band=4 after the BREAK period; frequency back to 14995000 -> stays at band 4.
REQ-036 Write thr[0]=1800000 during SCAN, with frequency=2000000 -> SCAN restarts, and band 1 is selected; reset asserted during BREAK -> LPF=0 and band=0 immediately.
